// File: rtl/rgb_fx_pkg.sv
// Shared definitions for the RGB strip effects controller: mode codes,
// the ten-entry colour palette, the pixel layout and the dimming helper.
package rgb_fx_pkg;

  localparam logic [2:0] MODE_OFF     = 3'd0;
  localparam logic [2:0] MODE_SOLID   = 3'd1;
  localparam logic [2:0] MODE_FLASH   = 3'd2;
  localparam logic [2:0] MODE_CHASE   = 3'd3;
  localparam logic [2:0] MODE_RAINBOW = 3'd4;

  localparam int NUM_COLORS = 10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // Indices 10..15 are not in the table; callers map them to black.
  localparam pixel_t PALETTE [NUM_COLORS] = '{
    24'hFFFFFF, 24'hFFFF00, 24'hFF6400, 24'hFF0000, 24'hFF00FF,
    24'h6400FF, 24'h0000FF, 24'h00FFFF, 24'h00FF00, 24'h006400
  };

  // Subtract the dimming offset from one channel, clamping at zero.
  // When d <= c the offset fits in 8 bits, so the low byte is exact.
  function automatic logic [7:0] sat_sub(input logic [7:0] c, input logic [8:0] d);
    return (d > {1'b0, c}) ? 8'd0 : (c - d[7:0]);
  endfunction

endpackage

// File: rtl/rgb_scale.sv
// Palette lookup followed by brightness dimming. Brightness 15 passes the
// palette colour unchanged; each step below that removes 17 from every
// channel, saturating at zero.
module rgb_scale
  import rgb_fx_pkg::*;
(
  input  logic [3:0] color_idx,
  input  logic [3:0] brightness,
  output pixel_t     pixel
);

  pixel_t     base;
  logic [8:0] d;

  // Look up the base colour and apply the saturating dimming offset.
  always_comb begin
    base    = (color_idx < 4'(NUM_COLORS)) ? PALETTE[color_idx] : '0;
    d       = 9'd17 * 9'(4'd15 - brightness);
    pixel.r = sat_sub(base.r, d);
    pixel.g = sat_sub(base.g, d);
    pixel.b = sat_sub(base.b, d);
  end

endmodule

// File: rtl/rgb_strip_fx.sv
// LED strip effects controller. Holds the animation state (prescaler,
// chase position, rainbow phase, flash polarity, latched mode) and the
// fully registered strip output. A change of mode restarts the animation:
// the frame produced on that cycle is the new mode's first frame.
module rgb_strip_fx
  import rgb_fx_pkg::*;
#(
  parameter int NUM_LEDS  = 10,
  parameter int FLASH_DIV = 4,
  parameter int STEP_DIV  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            mode,
  input  logic [3:0]            brightness,
  input  logic [3:0]            color_code,
  output logic [NUM_LEDS*24-1:0] strip
);

  localparam int MAX_DIV = (FLASH_DIV > STEP_DIV) ? FLASH_DIV : STEP_DIV;
  localparam int CNT_W   = $clog2(MAX_DIV);
  localparam int POS_W   = $clog2(NUM_LEDS);

  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_DIV - 1);
  localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST   = POS_W'(NUM_LEDS - 1);
  localparam logic [3:0]       PHASE_LAST = 4'(NUM_COLORS - 1);

  // All animation state in one struct so it can be observed as a unit.
  typedef struct packed {
    logic [2:0]       mode_q;
    logic             flash_on;
    logic [POS_W-1:0] pos;
    logic [3:0]       phase;
    logic [CNT_W-1:0] cnt;
  } fx_state_t;

  fx_state_t st;

  logic                   mode_chg;
  logic                   eff_flash_on;
  logic [POS_W-1:0]       eff_pos;
  logic [3:0]             eff_phase;
  pixel_t                 shared_px;
  logic [NUM_LEDS*24-1:0] rb_flat;
  logic [NUM_LEDS*24-1:0] frame;

  assign mode_chg = (mode != st.mode_q);

  // State the frame is drawn from: on a mode change the animation restarts.
  always_comb begin
    eff_flash_on = mode_chg ? 1'b1 : st.flash_on;
    eff_pos      = mode_chg ? '0   : st.pos;
    eff_phase    = mode_chg ? 4'd0 : st.phase;
  end

  rgb_scale u_shared (
    .color_idx (color_code),
    .brightness(brightness),
    .pixel     (shared_px)
  );

  // Rainbow: pixel i shows palette entry (i + phase) mod NUM_COLORS.
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_rainbow
    localparam logic [4:0] I_MOD = 5'(i % NUM_COLORS);
    logic [4:0] idx_sum;
    logic [3:0] idx;
    assign idx_sum = I_MOD + {1'b0, eff_phase};
    assign idx     = (idx_sum >= 5'(NUM_COLORS)) ? 4'(idx_sum - 5'(NUM_COLORS)) : idx_sum[3:0];
    rgb_scale u_scale (
      .color_idx (idx),
      .brightness(brightness),
      .pixel     (rb_flat[i*24 +: 24])
    );
  end

  // Assemble the next frame for the requested mode.
  always_comb begin
    frame = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      case (mode)
        MODE_SOLID:   frame[i*24 +: 24] = shared_px;
        MODE_FLASH:   if (eff_flash_on) frame[i*24 +: 24] = shared_px;
        MODE_CHASE:   if (eff_pos == POS_W'(i)) frame[i*24 +: 24] = shared_px;
        MODE_RAINBOW: frame[i*24 +: 24] = rb_flat[i*24 +: 24];
        default:      frame[i*24 +: 24] = '0;
      endcase
    end
  end

  // Animation state machine and registered strip output.
  always_ff @(posedge clk) begin
    if (rst) begin
      st.mode_q   <= MODE_OFF;
      st.flash_on <= 1'b1;
      st.pos      <= '0;
      st.phase    <= 4'd0;
      st.cnt      <= '0;
      strip       <= '0;
    end else begin
      strip <= frame;
      if (mode_chg) begin
        // The change cycle is period cycle 0, so the prescaler resumes at 1.
        st.mode_q   <= mode;
        st.flash_on <= 1'b1;
        st.pos      <= '0;
        st.phase    <= 4'd0;
        st.cnt      <= CNT_W'(1);
      end else begin
        case (st.mode_q)
          MODE_FLASH: begin
            if (st.cnt == FLASH_LAST) begin
              st.cnt      <= '0;
              st.flash_on <= ~st.flash_on;
            end else begin
              st.cnt <= st.cnt + 1'b1;
            end
          end
          MODE_CHASE: begin
            if (st.cnt == STEP_LAST) begin
              st.cnt <= '0;
              st.pos <= (st.pos == POS_LAST) ? '0 : st.pos + 1'b1;
            end else begin
              st.cnt <= st.cnt + 1'b1;
            end
          end
          MODE_RAINBOW: begin
            if (st.cnt == STEP_LAST) begin
              st.cnt   <= '0;
              st.phase <= (st.phase == PHASE_LAST) ? 4'd0 : st.phase + 4'd1;
            end else begin
              st.cnt <= st.cnt + 1'b1;
            end
          end
          default: st.cnt <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rgb_strip_fx.sv
// Bench for rgb_strip_fx with NUM_LEDS=4, FLASH_DIV=4, STEP_DIV=2.
// Directed table, hand-written animation sequences, then randomized
// traffic checked against a frame-count based reference model.
module tb_rgb_strip_fx;

  localparam int N = 4;
  localparam int W = N * 24;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [2:0]   mode = 3'd0;
  logic [3:0]   brightness = 4'd15;
  logic [3:0]   color_code = 4'd0;
  logic [W-1:0] strip;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         r;
    logic [2:0]   m;
    logic [3:0]   b;
    logic [3:0]   c;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Reference palette, rrggbb.
  int pal [10] = '{32'hFFFFFF, 32'hFFFF00, 32'hFF6400, 32'hFF0000, 32'hFF00FF,
                   32'h6400FF, 32'h0000FF, 32'h00FFFF, 32'h00FF00, 32'h006400};

  // Model state: latched mode and number of frames since the mode started.
  int m_mode_q = 0;
  int m_k = 0;

  // clock / reset block
  always #5 clk = ~clk;

  rgb_strip_fx #(.NUM_LEDS(N), .FLASH_DIV(4), .STEP_DIV(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .brightness(brightness),
    .color_code(color_code),
    .strip     (strip)
  );

  function automatic logic [23:0] ref_scale(input int c, input int b);
    int v, ch, res;
    res = 0;
    if (c > 9) return 24'h0;
    for (int s = 0; s < 3; s++) begin
      ch = (pal[c] >> (8 * s)) & 255;
      v = ch - 17 * (15 - b);
      if (v < 0) v = 0;
      res = res | (v << (8 * s));
    end
    return 24'(res);
  endfunction

  function automatic logic [W-1:0] all4(input logic [23:0] px);
    return {px, px, px, px};
  endfunction

  function automatic logic [W-1:0] one_px(input logic [23:0] px, input int p);
    logic [W-1:0] f;
    f = '0;
    f[p*24 +: 24] = px;
    return f;
  endfunction

  // Frame k cycles into a mode: flash halves last 4 frames, chase and
  // rainbow advance every 2 frames.
  function automatic logic [W-1:0] model_frame(input int m, input int b, input int c, input int k);
    logic [W-1:0] f;
    f = '0;
    for (int i = 0; i < N; i++) begin
      case (m)
        1: f[i*24 +: 24] = ref_scale(c, b);
        2: if (((k / 4) % 2) == 0) f[i*24 +: 24] = ref_scale(c, b);
        3: if (((k / 2) % N) == i) f[i*24 +: 24] = ref_scale(c, b);
        4: f[i*24 +: 24] = ref_scale((i + k / 2) % 10, b);
        default: f[i*24 +: 24] = 24'h0;
      endcase
    end
    return f;
  endfunction

  function automatic void model_advance(input logic r, input int m);
    if (r) begin
      m_mode_q = 0;
      m_k = 0;
    end else if (m != m_mode_q) begin
      m_mode_q = m;
      m_k = 0;
    end else begin
      m_k++;
    end
  endfunction

  task automatic check_strip(input string name);
    logic [W-1:0] want;
    want = exp_q.pop_front();
    checks++;
    if (strip !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, strip, want);
    end
  endtask

  task automatic check_px(input int p, input logic [23:0] want, input string name);
    checks++;
    if (strip[p*24 +: 24] !== want) begin
      errors++;
      $display("FAIL %s: pixel %0d got %h want %h", name, p, strip[p*24 +: 24], want);
    end
  endtask

  // driver: apply one cycle of inputs; expected value is explicit or from the model
  task automatic drive(input logic r, input logic [2:0] m, input logic [3:0] b, input logic [3:0] c,
                       input bit use_model, input logic [W-1:0] exp_in, input string name);
    rst = r; mode = m; brightness = b; color_code = c;
    model_advance(r, int'(m));
    if (use_model) exp_q.push_back(r ? '0 : model_frame(int'(m), int'(b), int'(c), m_k));
    else exp_q.push_back(exp_in);
    @(posedge clk);
    #1;
    check_strip(name);
  endtask

  initial begin
    logic [2:0] rm;
    logic [3:0] rb, rc;
    logic       rr;

    // Directed table: reset, off modes, solid scaling, first rainbow frames.
    vecs.push_back('{1'b1, 3'd1, 4'd15, 4'd5, '0});
    vecs.push_back('{1'b1, 3'd1, 4'd15, 4'd5, '0});
    vecs.push_back('{1'b0, 3'd0, 4'd15, 4'd5, '0});
    vecs.push_back('{1'b0, 3'd0, 4'd15, 4'd5, '0});
    vecs.push_back('{1'b0, 3'd6, 4'd15, 4'd5, '0});
    vecs.push_back('{1'b0, 3'd1, 4'd15, 4'd5, all4(24'h6400FF)});
    vecs.push_back('{1'b0, 3'd1, 4'd9,  4'd5, all4(24'h000099)});
    vecs.push_back('{1'b0, 3'd1, 4'd0,  4'd5, '0});
    vecs.push_back('{1'b0, 3'd1, 4'd15, 4'd12, '0});
    vecs.push_back('{1'b0, 3'd1, 4'd14, 4'd0, all4(24'hEEEEEE)});
    vecs.push_back('{1'b0, 3'd4, 4'd15, 4'd3, {24'hFF0000, 24'hFF6400, 24'hFFFF00, 24'hFFFFFF}});
    vecs.push_back('{1'b0, 3'd4, 4'd15, 4'd7, {24'hFF0000, 24'hFF6400, 24'hFFFF00, 24'hFFFFFF}});
    vecs.push_back('{1'b0, 3'd4, 4'd15, 4'd3, {24'hFF00FF, 24'hFF0000, 24'hFF6400, 24'hFFFF00}});

    @(posedge clk);
    #1;
    foreach (vecs[i]) drive(vecs[i].r, vecs[i].m, vecs[i].b, vecs[i].c, 1'b0, vecs[i].exp, $sformatf("vec%0d", i));

    // Rainbow continues to the phase wrap.
    for (int k = 3; k <= 21; k++) begin
      drive(1'b0, 3'd4, 4'd15, 4'd0, 1'b1, '0, $sformatf("rainbow_k%0d", k));
      if (k == 18) begin
        check_px(0, 24'h006400, "rainbow_wrap_p0");
        check_px(1, 24'hFFFFFF, "rainbow_wrap_p1");
      end
    end

    // Flash: 4 frames on, 4 off, three full periods.
    drive(1'b0, 3'd0, 4'd15, 4'd0, 1'b0, '0, "flash_pre_off");
    for (int j = 0; j < 24; j++)
      drive(1'b0, 3'd2, 4'd15, 4'd0, 1'b0, (((j / 4) % 2) == 0) ? all4(24'hFFFFFF) : '0,
            $sformatf("flash_%0d", j));

    // Chase: two frames per pixel, wrap from 3 back to 0.
    for (int j = 0; j < 10; j++)
      drive(1'b0, 3'd3, 4'd15, 4'd3, 1'b0, one_px(24'hFF0000, (j / 2) % N), $sformatf("chase_%0d", j));

    // Reset mid-chase with a brightness change along the way.
    drive(1'b0, 3'd0, 4'd15, 4'd3, 1'b0, '0, "chase2_pre_off");
    drive(1'b0, 3'd3, 4'd15, 4'd3, 1'b0, one_px(24'hFF0000, 0), "chase2_0");
    for (int j = 1; j < 5; j++)
      drive(1'b0, 3'd3, 4'd14, 4'd3, 1'b0, one_px(24'hEE0000, j / 2), $sformatf("chase2_%0d", j));
    drive(1'b1, 3'd3, 4'd14, 4'd3, 1'b0, '0, "chase2_rst");
    for (int j = 0; j < 6; j++)
      drive(1'b0, 3'd3, 4'd14, 4'd3, 1'b0, one_px(24'hEE0000, (j / 2) % N), $sformatf("chase2_rel_%0d", j));

    // Randomized traffic against the reference model.
    drive(1'b1, 3'd0, 4'd15, 4'd0, 1'b1, '0, "rand_rst");
    rm = 3'd0; rb = 4'd15; rc = 4'd0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) == 0) rm = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) rb = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rc = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 49) == 0);
      drive(rr, rm, rb, rc, 1'b1, '0, $sformatf("rand_%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
